// File: rtl/pipeline_ctrl_if.sv
// Handshake and control bundle between the pipeline datapath and pipeline_ctrl.
// The slave modport is the controller's view; master is the datapath/bench view.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             imem_resp;
    logic             dmem_resp;
    logic             mem_access;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             ex_br_taken;

    logic             pc_load;
    logic             if_id_load;
    logic             id_ex_load;
    logic             ex_mem_load;
    logic             mem_wb_load;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             advance;
    logic [CNT_W-1:0] stall_cnt;
    logic [15:0]      bubble_cnt;
    logic [15:0]      flush_cnt;

    modport slave (
        input  imem_resp, dmem_resp, mem_access, ex_is_load, ex_rd, id_rs1, id_rs2, ex_br_taken,
        output pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
               if_id_flush, id_ex_flush, advance, stall_cnt, bubble_cnt, flush_cnt
    );

    modport master (
        output imem_resp, dmem_resp, mem_access, ex_is_load, ex_rd, id_rs1, id_rs2, ex_br_taken,
        input  pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
               if_id_flush, id_ex_flush, advance, stall_cnt, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline step controller: joins instruction/data memory responses into a
// single advance, inserts load-use bubbles and branch flushes, and keeps perf counters.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        WAIT_BOTH = 2'd0,
        WAIT_I    = 2'd1,
        WAIT_D    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [15:0]      bubble_q, bubble_d;
    logic [15:0]      flush_q, flush_d;

    logic d_ok;
    logic step_done;
    logic advance;
    logic hz;
    logic do_bubble;
    logic do_flush;

    // A data response only counts when the MEM stage actually owns an access.
    assign d_ok = !bus.mem_access || bus.dmem_resp;

    assign hz = bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                ((bus.ex_rd == bus.id_rs1) || (bus.ex_rd == bus.id_rs2));

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        step_done = 1'b0;
        unique case (state_q)
            WAIT_BOTH: begin
                if (bus.imem_resp && d_ok) begin
                    step_done = 1'b1;
                end else if (bus.imem_resp) begin
                    state_d = WAIT_D;
                end else if (bus.mem_access && bus.dmem_resp) begin
                    state_d = WAIT_I;
                end
            end
            WAIT_I: step_done = bus.imem_resp;
            WAIT_D: step_done = bus.dmem_resp;
            default: state_d = WAIT_BOTH;
        endcase
        if (step_done) begin
            state_d = WAIT_BOTH;
        end
    end

    // Reset masks every output in the same cycle, including late responses.
    assign advance   = step_done && !rst;
    assign do_flush  = advance && bus.ex_br_taken;
    assign do_bubble = advance && hz && !bus.ex_br_taken;

    always_comb begin
        stall_d  = stall_q;
        bubble_d = bubble_q;
        flush_d  = flush_q;
        if (!advance && (stall_q != '1)) begin
            stall_d = stall_q + 1'b1;
        end
        if (do_bubble && (bubble_q != 16'hFFFF)) begin
            bubble_d = bubble_q + 16'd1;
        end
        if (do_flush && (flush_q != 16'hFFFF)) begin
            flush_d = flush_q + 16'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= WAIT_BOTH;
            stall_q  <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    assign bus.advance     = advance;
    assign bus.pc_load     = advance && !do_bubble;
    assign bus.if_id_load  = advance && !do_bubble;
    assign bus.id_ex_load  = advance;
    assign bus.ex_mem_load = advance;
    assign bus.mem_wb_load = advance;
    assign bus.if_id_flush = do_flush;
    assign bus.id_ex_flush = do_flush || do_bubble;
    assign bus.stall_cnt   = stall_q;
    assign bus.bubble_cnt  = bubble_q;
    assign bus.flush_cnt   = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: step joining, hazards, flushes, counters and reset.
module tb_pipeline_ctrl;

    logic clk;
    logic rst;
    logic rst2;
    int   checks;
    int   errors;

    pipeline_ctrl_if #(.CNT_W(32)) bus ();
    pipeline_ctrl_if #(.CNT_W(4))  bus2 ();

    pipeline_ctrl #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Narrow stall counter instance so saturation is reachable in a short run.
    pipeline_ctrl #(.CNT_W(4)) dut_sat (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] loads();
        return {bus.pc_load, bus.if_id_load, bus.id_ex_load, bus.ex_mem_load, bus.mem_wb_load};
    endfunction

    function automatic logic [1:0] flushes();
        return {bus.if_id_flush, bus.id_ex_flush};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.imem_resp   = 1'b0;
        bus.dmem_resp   = 1'b0;
        bus.mem_access  = 1'b0;
        bus.ex_is_load  = 1'b0;
        bus.ex_rd       = 5'd0;
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.ex_br_taken = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        bus.imem_resp = 1'b1;
        next_cycle();
        #1;
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL reset_advance got %b exp 0", bus.advance); end
        checks++; if (loads() !== 5'b00000) begin errors++; $display("FAIL reset_loads got %b exp 00000", loads()); end
        next_cycle();
        checks++; if (bus.stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", bus.stall_cnt); end
        checks++; if (bus.bubble_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_counters got bubble=%0d flush=%0d exp 0/0", bus.bubble_cnt, bus.flush_cnt);
        end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL basic_stall_c%0d got %b exp 0", i, bus.advance); end
            next_cycle();
        end
        bus.imem_resp = 1'b1;
        #1;
        checks++; if (bus.advance !== 1'b1) begin errors++; $display("FAIL basic_advance got %b exp 1", bus.advance); end
        checks++; if (loads() !== 5'b11111) begin errors++; $display("FAIL basic_loads got %b exp 11111", loads()); end
        checks++; if (flushes() !== 2'b00) begin errors++; $display("FAIL basic_flushes got %b exp 00", flushes()); end
        next_cycle();
        bus.imem_resp = 1'b0;
        #1;
        checks++; if (bus.stall_cnt !== 32'd3) begin errors++; $display("FAIL basic_stall_cnt got %0d exp 3", bus.stall_cnt); end
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL basic_one_shot got %b exp 0", bus.advance); end
        next_cycle();
    endtask

    task automatic test_wait_i();
        bus.mem_access = 1'b1;
        #1;
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL waiti_c0 got %b exp 0", bus.advance); end
        next_cycle();
        bus.dmem_resp = 1'b1;
        #1;
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL waiti_dmem got %b exp 0", bus.advance); end
        next_cycle();
        #1;
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL waiti_dup_dmem got %b exp 0", bus.advance); end
        next_cycle();
        bus.dmem_resp = 1'b0;
        #1;
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL waiti_c3 got %b exp 0", bus.advance); end
        next_cycle();
        bus.imem_resp = 1'b1;
        #1;
        checks++; if (bus.advance !== 1'b1) begin errors++; $display("FAIL waiti_advance got %b exp 1", bus.advance); end
        checks++; if (loads() !== 5'b11111) begin errors++; $display("FAIL waiti_loads got %b exp 11111", loads()); end
        next_cycle();
        idle();
        #1;
        checks++; if (bus.stall_cnt !== 32'd8) begin errors++; $display("FAIL waiti_stall_cnt got %0d exp 8", bus.stall_cnt); end
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL waiti_after got %b exp 0", bus.advance); end
        next_cycle();
    endtask

    task automatic test_load_use();
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 5'd5;
        bus.id_rs1     = 5'd3;
        bus.id_rs2     = 5'd5;
        bus.imem_resp  = 1'b1;
        #1;
        checks++; if (loads() !== 5'b00111) begin errors++; $display("FAIL lu_loads got %b exp 00111", loads()); end
        checks++; if (flushes() !== 2'b01) begin errors++; $display("FAIL lu_flushes got %b exp 01", flushes()); end
        checks++; if (bus.bubble_cnt !== 16'd0) begin errors++; $display("FAIL lu_bubble_before got %0d exp 0", bus.bubble_cnt); end
        next_cycle();
        // Hazard and branch while stalled must have no effect.
        bus.imem_resp   = 1'b0;
        bus.ex_br_taken = 1'b1;
        #1;
        checks++; if (bus.bubble_cnt !== 16'd1) begin errors++; $display("FAIL lu_bubble_after got %0d exp 1", bus.bubble_cnt); end
        checks++; if (bus.stall_cnt !== 32'd9) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 9", bus.stall_cnt); end
        checks++; if ({loads(), flushes()} !== 7'b0) begin errors++; $display("FAIL lu_stalled_outs got %b exp 0000000", {loads(), flushes()}); end
        next_cycle();
        checks++; if (bus.flush_cnt !== 16'd0 || bus.bubble_cnt !== 16'd1) begin
            errors++; $display("FAIL lu_stalled_counts got flush=%0d bubble=%0d exp 0/1", bus.flush_cnt, bus.bubble_cnt);
        end
        idle();
    endtask

    task automatic test_branch();
        bus.ex_is_load  = 1'b1;
        bus.ex_rd       = 5'd5;
        bus.id_rs2      = 5'd5;
        bus.ex_br_taken = 1'b1;
        bus.imem_resp   = 1'b1;
        #1;
        checks++; if (loads() !== 5'b11111) begin errors++; $display("FAIL br_loads got %b exp 11111", loads()); end
        checks++; if (flushes() !== 2'b11) begin errors++; $display("FAIL br_flushes got %b exp 11", flushes()); end
        next_cycle();
        idle();
        #1;
        checks++; if (bus.flush_cnt !== 16'd1) begin errors++; $display("FAIL br_flush_cnt got %0d exp 1", bus.flush_cnt); end
        checks++; if (bus.bubble_cnt !== 16'd1) begin errors++; $display("FAIL br_bubble_cnt got %0d exp 1", bus.bubble_cnt); end
        checks++; if (bus.stall_cnt !== 32'd10) begin errors++; $display("FAIL br_stall_cnt got %0d exp 10", bus.stall_cnt); end
        next_cycle();
    endtask

    task automatic test_rd_zero();
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 5'd0;
        bus.id_rs1     = 5'd0;
        bus.id_rs2     = 5'd7;
        bus.imem_resp  = 1'b1;
        #1;
        checks++; if (loads() !== 5'b11111) begin errors++; $display("FAIL rd0_loads got %b exp 11111", loads()); end
        checks++; if (flushes() !== 2'b00) begin errors++; $display("FAIL rd0_flushes got %b exp 00", flushes()); end
        next_cycle();
        idle();
        #1;
        checks++; if (bus.bubble_cnt !== 16'd1) begin errors++; $display("FAIL rd0_bubble_cnt got %0d exp 1", bus.bubble_cnt); end
        checks++; if (bus.stall_cnt !== 32'd11) begin errors++; $display("FAIL rd0_stall_cnt got %0d exp 11", bus.stall_cnt); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        bus.mem_access = 1'b1;
        bus.dmem_resp  = 1'b1;
        bus.imem_resp  = 1'b1;
        #1;
        checks++; if (bus.advance !== 1'b1) begin errors++; $display("FAIL b2b_both got %b exp 1", bus.advance); end
        next_cycle();
        bus.mem_access = 1'b0;
        bus.dmem_resp  = 1'b0;
        #1;
        checks++; if (bus.advance !== 1'b1) begin errors++; $display("FAIL b2b_nomem got %b exp 1", bus.advance); end
        next_cycle();
        bus.ex_is_load = 1'b1;
        bus.ex_rd      = 5'd9;
        bus.id_rs1     = 5'd9;
        bus.id_rs2     = 5'd2;
        #1;
        checks++; if (loads() !== 5'b00111) begin errors++; $display("FAIL b2b_rs1_hz got %b exp 00111", loads()); end
        next_cycle();
        idle();
        #1;
        checks++; if (bus.bubble_cnt !== 16'd2) begin errors++; $display("FAIL b2b_bubble_cnt got %0d exp 2", bus.bubble_cnt); end
        checks++; if (bus.stall_cnt !== 32'd12) begin errors++; $display("FAIL b2b_stall_cnt got %0d exp 12", bus.stall_cnt); end
        next_cycle();
    endtask

    task automatic test_dmem_ignored();
        bus.dmem_resp = 1'b1;
        #1;
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL dign_c0 got %b exp 0", bus.advance); end
        next_cycle();
        bus.dmem_resp  = 1'b0;
        bus.mem_access = 1'b1;
        bus.imem_resp  = 1'b1;
        #1;
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL dign_no_credit got %b exp 0", bus.advance); end
        next_cycle();
        bus.imem_resp = 1'b0;
        bus.dmem_resp = 1'b1;
        #1;
        checks++; if (bus.advance !== 1'b1) begin errors++; $display("FAIL dign_waitd_done got %b exp 1", bus.advance); end
        next_cycle();
        idle();
        #1;
        checks++; if (bus.stall_cnt !== 32'd15) begin errors++; $display("FAIL dign_stall_cnt got %0d exp 15", bus.stall_cnt); end
        next_cycle();
    endtask

    task automatic test_reset_mid_step();
        bus.mem_access = 1'b1;
        bus.imem_resp  = 1'b1;
        #1;
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL rmid_enter_waitd got %b exp 0", bus.advance); end
        next_cycle();
        rst           = 1'b1;
        bus.imem_resp = 1'b1;
        bus.dmem_resp = 1'b1;
        #1;
        checks++; if ({bus.advance, loads(), flushes()} !== 8'b0) begin
            errors++; $display("FAIL rmid_rst_outs got %b exp 00000000", {bus.advance, loads(), flushes()});
        end
        next_cycle();
        rst           = 1'b0;
        bus.imem_resp = 1'b0;
        #1;
        checks++; if (bus.stall_cnt !== 32'd0 || bus.bubble_cnt !== 16'd0 || bus.flush_cnt !== 16'd0) begin
            errors++; $display("FAIL rmid_counters got stall=%0d bubble=%0d flush=%0d exp 0/0/0",
                               bus.stall_cnt, bus.bubble_cnt, bus.flush_cnt);
        end
        checks++; if (bus.advance !== 1'b0) begin errors++; $display("FAIL rmid_fresh_step got %b exp 0", bus.advance); end
        next_cycle();
        bus.dmem_resp = 1'b0;
        bus.imem_resp = 1'b1;
        #1;
        checks++; if (bus.advance !== 1'b1) begin errors++; $display("FAIL rmid_advance got %b exp 1", bus.advance); end
        next_cycle();
        idle();
        #1;
        checks++; if (bus.stall_cnt !== 32'd1) begin errors++; $display("FAIL rmid_stall_cnt got %0d exp 1", bus.stall_cnt); end
        next_cycle();
    endtask

    task automatic test_stall_saturation();
        rst2 = 1'b0;
        repeat (14) next_cycle();
        checks++; if (bus2.stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_pre got %0d exp 14", bus2.stall_cnt); end
        next_cycle();
        checks++; if (bus2.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_max got %0d exp 15", bus2.stall_cnt); end
        repeat (5) next_cycle();
        checks++; if (bus2.stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", bus2.stall_cnt); end
        checks++; if (bus2.advance !== 1'b0) begin errors++; $display("FAIL sat_advance got %b exp 0", bus2.advance); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        rst2   = 1'b1;
        idle();
        bus2.imem_resp   = 1'b0;
        bus2.dmem_resp   = 1'b0;
        bus2.mem_access  = 1'b0;
        bus2.ex_is_load  = 1'b0;
        bus2.ex_rd       = 5'd0;
        bus2.id_rs1      = 5'd0;
        bus2.id_rs2      = 5'd0;
        bus2.ex_br_taken = 1'b0;
        next_cycle();
        test_reset();
        test_basic();
        test_wait_i();
        test_load_use();
        test_branch();
        test_rd_zero();
        test_back_to_back();
        test_dmem_ignored();
        test_reset_mid_step();
        test_stall_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter: CNT_W, 32, width of the stall_cnt perf counter; bubble_cnt and flush_cnt are fixed at 16 bits.
REQ-002 clk  in  1  clock; all state updates on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 imem_resp  in  1  single-cycle pulse: the instruction fetch for the current step is complete.
REQ-005 dmem_resp  in  1  single-cycle pulse: the MEM-stage data access is complete.
REQ-006 mem_access  in  1  MEM-stage instruction is a load or store; held stable for the whole step.
REQ-007 ex_is_load  in  1  EX-stage instruction is a load.
REQ-008 ex_rd  in  5  EX-stage destination register.
REQ-009 id_rs1, id_rs2  in  5 each  ID-stage source registers.
REQ-010 ex_br_taken  in  1  EX-stage branch or jump redirects the PC.
REQ-011 pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  pipeline register load enables.
REQ-012 if_id_flush, id_ex_flush  out  1 each  replace the register contents with a NOP bubble on load.
REQ-013 advance  out  1  the current step completes this cycle.
REQ-014 stall_cnt  out  CNT_W; bubble_cnt, flush_cnt  out  16 each  performance counters.

Function
REQ-015 FSM states: WAIT_BOTH (no response yet), WAIT_I (data done, fetch outstanding), WAIT_D (fetch done, data outstanding).
REQ-016 WAIT_BOTH, define d_ok = !mem_access | dmem_resp: advance = imem_resp & d_ok; imem_resp & !d_ok -> WAIT_D; !imem_resp & mem_access & dmem_resp -> WAIT_I; otherwise stay.
REQ-017 WAIT_I: advance = imem_resp, then go to WAIT_BOTH; otherwise stay.
REQ-018 WAIT_D: advance = dmem_resp, then go to WAIT_BOTH; otherwise stay.
REQ-019 Every advance returns the FSM to WAIT_BOTH; advance is combinational, in the same cycle as the final response (zero-cycle latency).
REQ-020 dmem_resp with mem_access=0 is ignored; a second response of an already-completed kind within a step is ignored.
REQ-021 No advance: all load and flush outputs are 0.
REQ-022 Normal advance: all five loads are 1 and both flushes are 0.
REQ-023 Load-use hazard: hz = ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-024 Advance with hz & !ex_br_taken: pc_load=0, if_id_load=0, id_ex_load=1, id_ex_flush=1, ex_mem_load=1, mem_wb_load=1.
REQ-025 Advance with ex_br_taken: all loads 1, if_id_flush=1, id_ex_flush=1; ex_br_taken takes priority over hz.
REQ-026 ex_br_taken and hz are evaluated only in the advance cycle; their values in stalled cycles have no effect.
REQ-027 stall_cnt increments by 1 each non-reset cycle with advance=0 and saturates at all-ones.
REQ-028 bubble_cnt increments on each REQ-024 advance and saturates at 0xFFFF.
REQ-029 flush_cnt increments on each REQ-025 advance and saturates at 0xFFFF.

Reset
REQ-030 While rst=1, the FSM goes to WAIT_BOTH, all counters clear to 0, and all load, flush and advance outputs are 0, regardless of other inputs.
REQ-031 rst asserted mid-step discards any partial response progress; the first step after reset requires fresh responses.
REQ-032 Responses arriving in the same cycle as rst=1 are discarded.

Verification
REQ-033 After reset, mem_access=0 and imem_resp pulsed in cycle 3 -> advance=1 with all loads=1 in cycle 3 only; stall_cnt=3 afterwards (cycles 0-2 stalled).
REQ-034 mem_access=1, dmem_resp in cycle 1, imem_resp in cycle 4 -> FSM goes to WAIT_I; advance only in cycle 4; the duplicate dmem_resp in cycle 2 is ignored.
REQ-035 ex_is_load=1, ex_rd=5, id_rs2=5, advance -> pc_load=0, if_id_load=0, id_ex_flush=1, ex_mem_load=1; bubble_cnt 0->1.
REQ-036 hz true with ex_br_taken=1 on the same advance -> all loads=1, if_id_flush=1, id_ex_flush=1; flush_cnt +1, bubble_cnt unchanged.
REQ-037 ex_rd=0 with id_rs1=0 and ex_is_load=1 -> no bubble; stall_cnt preloaded near all-ones via a long stall saturates with no wrap to 0.
REQ-038 rst pulsed in WAIT_D -> next step requires both imem_resp and dmem_resp; all counters read 0.
